// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: state enum, opcodes and mux/ALU codes.
// Build option: define MC_JUMP_EN to decode the j instruction (adds the JEX state).
package mc_pkg;

`ifdef MC_JUMP_EN
  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR,
    ST_RTYPEEX, ST_ALUWB, ST_BEQEX, ST_ADDIEX, ST_ADDIWB, ST_JEX
  } state_t;
`else
  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR,
    ST_RTYPEEX, ST_ALUWB, ST_BEQEX, ST_ADDIEX, ST_ADDIWB
  } state_t;
`endif

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
         (op == OP_BEQ) || (op == OP_ADDI);
`ifdef MC_JUMP_EN
    ok = ok || (op == OP_J);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_outdec.sv
// Combinational state-to-control decode for multicycle_ctrl (MC_JUMP_EN adds the JEX decode).
// Strobes are forced low while reset_n is asserted so nothing fires during reset.
module multicycle_outdec
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       memrdy,
  input  logic       zero,
  input  logic       reset_n,
  output logic       memreq,
  output logic       lord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       pcen,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] pcsrc,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       illop
);

  always_comb begin
    memreq   = 1'b0;
    lord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    alusrca  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    pcsrc    = PCSRC_ALU;
    alusrcb  = ALUSRCB_REG;
    aluop    = ALUOP_ADD;
    illop    = 1'b0;
    if (!reset_n) begin
      alusrcb = ALUSRCB_FOUR;
    end else begin
      case (state)
        ST_FETCH: begin
          memreq  = 1'b1;
          alusrcb = ALUSRCB_FOUR;
          irwrite = memrdy;
          pcwrite = memrdy;
        end
        ST_DECODE: begin
          alusrcb = ALUSRCB_IMMSH;
          illop   = !op_legal(op);
        end
        ST_MEMADR, ST_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = ALUSRCB_IMM;
        end
        ST_MEMRD: begin
          memreq = 1'b1;
          lord   = 1'b1;
        end
        ST_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        ST_MEMWR: begin
          memreq   = 1'b1;
          lord     = 1'b1;
          memwrite = 1'b1;
        end
        ST_RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        ST_ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        ST_BEQEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = PCSRC_ALUOUT;
          branch  = 1'b1;
        end
        ST_ADDIWB: regwrite = 1'b1;
`ifdef MC_JUMP_EN
        ST_JEX: begin
          pcsrc   = PCSRC_JUMP;
          pcwrite = 1'b1;
        end
`endif
        default: ;
      endcase
    end
    pcen = pcwrite | (branch & zero);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: state register and next-state logic; outputs via multicycle_outdec.
// Build option: MC_JUMP_EN enables the j instruction; without it opcode 000010 is illegal.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memrdy,
  output logic       memreq,
  output logic       lord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       pcen,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] pcsrc,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       illop
);

  state_t state, state_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:   if (memrdy) state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = ST_MEMADR;
          OP_RTYPE:     state_nxt = ST_RTYPEEX;
          OP_BEQ:       state_nxt = ST_BEQEX;
          OP_ADDI:      state_nxt = ST_ADDIEX;
`ifdef MC_JUMP_EN
          OP_J:         state_nxt = ST_JEX;
`endif
          default:      state_nxt = ST_FETCH;
        endcase
      end
      // op is only looked at here and in DECODE; the instruction register keeps it stable
      ST_MEMADR: begin
        if (op == OP_SW)      state_nxt = ST_MEMWR;
        else if (op == OP_LW) state_nxt = ST_MEMRD;
        else                  state_nxt = ST_FETCH;
      end
      ST_MEMRD:   if (memrdy) state_nxt = ST_MEMWB;
      ST_MEMWR:   if (memrdy) state_nxt = ST_FETCH;
      ST_RTYPEEX: state_nxt = ST_ALUWB;
      ST_ADDIEX:  state_nxt = ST_ADDIWB;
      default:    state_nxt = ST_FETCH;
    endcase
  end

  multicycle_outdec u_outdec (
    .state    (state),
    .op       (op),
    .memrdy   (memrdy),
    .zero     (zero),
    .reset_n  (reset_n),
    .memreq   (memreq),
    .lord     (lord),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .pcwrite  (pcwrite),
    .branch   (branch),
    .pcen     (pcen),
    .alusrca  (alusrca),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .pcsrc    (pcsrc),
    .alusrcb  (alusrcb),
    .aluop    (aluop),
    .illop    (illop)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors are queued by the
// stimulus process and checked by an independent monitor on the falling clock edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       memrdy;
  logic       memreq, lord, memwrite, irwrite, pcwrite, branch, pcen;
  logic       alusrca, regdst, memtoreg, regwrite, illop;
  logic [1:0] pcsrc, alusrcb, aluop;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .memrdy(memrdy),
    .memreq(memreq), .lord(lord), .memwrite(memwrite), .irwrite(irwrite),
    .pcwrite(pcwrite), .branch(branch), .pcen(pcen), .alusrca(alusrca),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .pcsrc(pcsrc), .alusrcb(alusrcb), .aluop(aluop), .illop(illop)
  );

  always #5 clk = ~clk;

  // {memreq,lord,memwrite,irwrite,pcwrite,branch,pcen,alusrca,regdst,memtoreg,regwrite,pcsrc,alusrcb,aluop,illop}
  localparam logic [17:0] E_RST     = 18'b0_0_0_0_0_0_0_0_0_0_0_00_01_00_0;
  localparam logic [17:0] E_FETCH0  = 18'b1_0_0_0_0_0_0_0_0_0_0_00_01_00_0;
  localparam logic [17:0] E_FETCH1  = 18'b1_0_0_1_1_0_1_0_0_0_0_00_01_00_0;
  localparam logic [17:0] E_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_0_00_11_00_0;
  localparam logic [17:0] E_DECILL  = 18'b0_0_0_0_0_0_0_0_0_0_0_00_11_00_1;
  localparam logic [17:0] E_MEMADR  = 18'b0_0_0_0_0_0_0_1_0_0_0_00_10_00_0;
  localparam logic [17:0] E_MEMRD   = 18'b1_1_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] E_MEMWB   = 18'b0_0_0_0_0_0_0_0_0_1_1_00_00_00_0;
  localparam logic [17:0] E_MEMWR   = 18'b1_1_1_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] E_RTYPEEX = 18'b0_0_0_0_0_0_0_1_0_0_0_00_00_10_0;
  localparam logic [17:0] E_ALUWB   = 18'b0_0_0_0_0_0_0_0_1_0_1_00_00_00_0;
  localparam logic [17:0] E_BEQ_Z1  = 18'b0_0_0_0_0_1_1_1_0_0_0_01_00_01_0;
  localparam logic [17:0] E_BEQ_Z0  = 18'b0_0_0_0_0_1_0_1_0_0_0_01_00_01_0;
  localparam logic [17:0] E_ADDIEX  = 18'b0_0_0_0_0_0_0_1_0_0_0_00_10_00_0;
  localparam logic [17:0] E_ADDIWB  = 18'b0_0_0_0_0_0_0_0_0_0_1_00_00_00_0;
  localparam logic [17:0] E_JEX     = 18'b0_0_0_0_1_0_1_0_0_0_0_10_00_00_0;

  logic [17:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          stim_done = 1'b0;

  wire [17:0] act = {memreq, lord, memwrite, irwrite, pcwrite, branch, pcen, alusrca,
                     regdst, memtoreg, regwrite, pcsrc, alusrcb, aluop, illop};

  task automatic step(input logic rn, input logic [5:0] o, input logic z, input logic m,
                      input logic [17:0] e, input string nm);
    @(posedge clk);
    #1;
    reset_n = rn;
    op      = o;
    zero    = z;
    memrdy  = m;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every cycle with a pending expectation is one comparison
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [17:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s: got %b want %b", nm, act, e);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    op      = 6'b000000;
    zero    = 1'b0;
    memrdy  = 1'b0;

    step(0, 6'b100011, 0, 1, E_RST,    "reset_0");
    step(0, 6'b100011, 1, 1, E_RST,    "reset_1");

    // lw, memrdy=1: five cycles
    step(1, 6'b100011, 0, 1, E_FETCH1, "lw_fetch");
    step(1, 6'b100011, 0, 1, E_DECODE, "lw_decode");
    step(1, 6'b100011, 0, 1, E_MEMADR, "lw_memadr");
    step(1, 6'b100011, 0, 1, E_MEMRD,  "lw_memrd");
    step(1, 6'b100011, 0, 1, E_MEMWB,  "lw_memwb");

    // sw with one wait cycle in MEMWR
    step(1, 6'b101011, 0, 1, E_FETCH1, "sw_fetch");
    step(1, 6'b101011, 0, 1, E_DECODE, "sw_decode");
    step(1, 6'b101011, 0, 1, E_MEMADR, "sw_memadr");
    step(1, 6'b101011, 0, 0, E_MEMWR,  "sw_memwr_wait");
    step(1, 6'b101011, 0, 1, E_MEMWR,  "sw_memwr_done");

    // R-type
    step(1, 6'b000000, 0, 1, E_FETCH1,  "r_fetch");
    step(1, 6'b000000, 0, 1, E_DECODE,  "r_decode");
    step(1, 6'b000000, 0, 1, E_RTYPEEX, "r_ex");
    step(1, 6'b000000, 0, 1, E_ALUWB,   "r_wb");

    // beq taken, then not taken
    step(1, 6'b000100, 1, 1, E_FETCH1, "beq1_fetch");
    step(1, 6'b000100, 1, 1, E_DECODE, "beq1_decode");
    step(1, 6'b000100, 1, 1, E_BEQ_Z1, "beq1_ex_taken");
    step(1, 6'b000100, 0, 1, E_FETCH1, "beq0_fetch");
    step(1, 6'b000100, 0, 1, E_DECODE, "beq0_decode");
    step(1, 6'b000100, 0, 1, E_BEQ_Z0, "beq0_ex_nottaken");

    // addi
    step(1, 6'b001000, 0, 1, E_FETCH1, "addi_fetch");
    step(1, 6'b001000, 0, 1, E_DECODE, "addi_decode");
    step(1, 6'b001000, 0, 1, E_ADDIEX, "addi_ex");
    step(1, 6'b001000, 0, 1, E_ADDIWB, "addi_wb");

    // FETCH stalls three cycles, then an illegal opcode
    step(1, 6'b111111, 0, 0, E_FETCH0, "stall_0");
    step(1, 6'b111111, 0, 0, E_FETCH0, "stall_1");
    step(1, 6'b111111, 0, 0, E_FETCH0, "stall_2");
    step(1, 6'b111111, 0, 1, E_FETCH1, "stall_release");
    step(1, 6'b111111, 0, 1, E_DECILL, "ill_decode");

    // jump: JEX when enabled, illegal otherwise
    step(1, 6'b000010, 0, 1, E_FETCH1, "j_fetch");
`ifdef MC_JUMP_EN
    step(1, 6'b000010, 0, 1, E_DECODE, "j_decode");
    step(1, 6'b000010, 0, 1, E_JEX,    "j_ex");
`else
    step(1, 6'b000010, 0, 1, E_DECILL, "j_decode_illegal");
`endif

    // reset asserted while MEMWR waits on memory
    step(1, 6'b101011, 0, 1, E_FETCH1, "swr_fetch");
    step(1, 6'b101011, 0, 1, E_DECODE, "swr_decode");
    step(1, 6'b101011, 0, 1, E_MEMADR, "swr_memadr");
    step(1, 6'b101011, 0, 0, E_MEMWR,  "swr_memwr_wait");
    step(0, 6'b101011, 0, 0, E_RST,    "swr_reset_mid");
    step(1, 6'b101011, 0, 0, E_FETCH0, "swr_after_reset");
    step(1, 6'b101011, 0, 1, E_FETCH1, "swr_refetch");
    step(1, 6'b101011, 0, 1, E_DECODE, "swr_redecode");

    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
